// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_IFETCH = 2'd1,
    GRANT_DATA   = 2'd2
  } bus_grant_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_I_ACC = 2'd1,
    ARB_D_ACC = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// bus_watchdog: counts stalled access cycles and flags the cycle whose tick reaches LIMIT.
module bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expire on the tick that would bring the count to LIMIT, so the owner sees exactly LIMIT
  // strobe cycles before the abort.
  assign expired = tick && (cnt_q == CntW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between ifetch and data ports.
// Define BUS_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without mem_ready.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [1:0]          grant,
  output logic                bus_err,
  output logic                stall
);

  localparam int unsigned BeW = DATA_W / 8;

  arb_state_t        state_q, state_d;
  bus_grant_t        grant_q, grant_d;
  bus_grant_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]    be_q, be_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              in_acc;
  logic              timeout;

  assign in_acc = (state_q == ARB_I_ACC) || (state_q == ARB_D_ACC);

`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_acc),
    .tick   (in_acc && !mem_ready),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    re_d      = re_q;
    we_d      = we_q;
    err_d     = err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        // Data wins unless it was the previous owner and ifetch is also waiting.
        if (d_req && (!i_req || (last_q != GRANT_DATA))) begin
          state_d = ARB_D_ACC;
          grant_d = GRANT_DATA;
          last_d  = GRANT_DATA;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_we ? d_be : '1;
          re_d    = !d_we;
          we_d    = d_we;
          err_d   = 1'b0;
        end else if (i_req) begin
          state_d = ARB_I_ACC;
          grant_d = GRANT_IFETCH;
          last_d  = GRANT_IFETCH;
          addr_d  = i_addr;
          wdata_d = '0;
          be_d    = '1;
          re_d    = 1'b1;
          we_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      ARB_I_ACC, ARB_D_ACC: begin
        if (mem_ready || timeout) begin
          state_d = ARB_RESP;
          grant_d = GRANT_NONE;
          re_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = !mem_ready;
          if (state_q == ARB_I_ACC) begin
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else if (!mem_ready) begin
            d_rdata_d = '0;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= GRANT_NONE;
      last_q    <= GRANT_IFETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      re_q      <= re_d;
      we_q      <= we_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // last_q names the owner while in RESP, since it was updated on entry to ACC.
  assign i_done    = (state_q == ARB_RESP) && (last_q == GRANT_IFETCH);
  assign d_done    = (state_q == ARB_RESP) && (last_q == GRANT_DATA);
  assign bus_err   = (state_q == ARB_RESP) && err_q;
  assign stall     = (i_req && !i_done) || (d_req && !d_done);
  assign grant     = grant_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level requester/memory model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;
  logic          bus_err;
  logic          stall;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .grant    (grant),
    .bus_err  (bus_err),
    .stall    (stall)
  );

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] i_rd_m, d_rd_m;
  bit            last_data;  // previous bus owner was the data port
  bit            won;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
    d_be    = 4'($urandom_range(1, 15));
  endtask

  task automatic model_reset();
    last_data = 1'b0;
    i_rd_m    = '0;
    d_rd_m    = '0;
  endtask

  task automatic idle_check();
    check("idle_grant", grant, 0);
    check("idle_re", mem_re, 0);
    check("idle_we", mem_we, 0);
    check("idle_done", {i_done, d_done}, 0);
    check("idle_stall", stall, i_req || d_req);
  endtask

  // Called in an idle cycle with at least one request up; ends in the done cycle.
  task automatic run_access(input int waits, output bit won_data);
    bit            pick_d, ere, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, rd;
    logic [BW-1:0] eb;
    pick_d   = d_req && (!i_req || !last_data);
    won_data = pick_d;
    if (pick_d) begin
      ea = d_addr; ew = d_wdata; eb = d_we ? d_be : '1; ere = !d_we; ewe = d_we;
    end else begin
      ea = i_addr; ew = '0; eb = '1; ere = 1'b1; ewe = 1'b0;
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    check("acc_re", mem_re, ere);
    check("acc_we", mem_we, ewe);
    check("acc_addr", mem_addr, ea);
    check("acc_be", mem_be, eb);
    if (ewe) check("acc_wdata", mem_wdata, ew);
    check("acc_grant", grant, pick_d ? 2 : 1);
    check("acc_stall", stall, 1);
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      step();
      check("hold_strobe", {mem_re, mem_we}, {ere, ewe});
      check("hold_addr", mem_addr, ea);
      check("hold_be", mem_be, eb);
      check("hold_done", {i_done, d_done}, 0);
    end
    rd        = mem_m[ea[5:2]];
    mem_rdata = ere ? rd : $urandom;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (ewe) mem_m[ea[5:2]] = merge(mem_m[ea[5:2]], ew, eb);
    if (!pick_d) i_rd_m = rd;
    else if (ere) d_rd_m = rd;
    last_data = pick_d;
    check("resp_i_done", i_done, !pick_d);
    check("resp_d_done", d_done, pick_d);
    check("resp_grant", grant, 0);
    check("resp_strobe", {mem_re, mem_we}, 0);
    check("resp_err", bus_err, 0);
    check("resp_i_rdata", i_rdata, i_rd_m);
    check("resp_d_rdata", d_rdata, d_rd_m);
    check("resp_stall", stall, pick_d ? i_req : d_req);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    for (int a = 0; a < 16; a++) mem_m[a] = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_strobe", {mem_re, mem_we}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_done_err", {i_done, d_done, bus_err}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    // Tie after reset: data, then ifetch against a fresh data request, then data.
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    run_access(0, won);
    d_addr = 32'h84;
    step(); idle_check();
    run_access(1, won);
    i_req = 1'b0;
    step(); idle_check();
    run_access(0, won);
    d_req = 1'b0;
    step(); idle_check();

    // Single fetch.
    i_req = 1'b1; i_addr = 32'h100;
    mem_m[(32'h100 >> 2) & 15] = 32'h0050_0093;
    run_access(0, won);
    check("fetch_word", i_rdata, 32'h0050_0093);
    check("fetch_stall", stall, 0);
    i_req = 1'b0;
    step(); idle_check();

    // Store with three wait states.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    run_access(3, won);
    check("store_be", 64'(mem_m[(32'h2000 >> 2) & 15][15:0]), 64'h0000_BEEF);
    d_req = 1'b0;
    step(); idle_check();

    // Reset in the middle of a data access; held requests re-arbitrate afterwards.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = $urandom; d_be = 4'hF;
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b0;
    check("mid_we", mem_we, 1);
    new_i();
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_strobe", {mem_re, mem_we}, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_done", {i_done, d_done}, 0);
    check("mid_rst_rdata", {i_rdata, d_rdata}, 0);
    check("mid_rst_stall", stall, 1);
    #1;
    rst = 1'b0;
    run_access(1, won);
    d_req = 1'b0;
    step(); idle_check();
    run_access(0, won);
    i_req = 1'b0;
    step(); idle_check();

    // Access that never sees mem_ready.
    i_req = 1'b1; i_addr = 32'h500;
    mem_ready = 1'b0;
    step();
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      check("to_re", mem_re, 1);
      check("to_done", i_done, 0);
      step();
    end
    i_rd_m = '0;
    last_data = 1'b0;
    check("to_re_drop", mem_re, 0);
    check("to_done_err", {i_done, bus_err}, 2'b11);
    check("to_rdata", i_rdata, i_rd_m);
    i_req = 1'b0;
    step(); idle_check();
    check("to_err_clear", bus_err, 0);
`else
    begin
      bit seen;
      seen = 1'b0;
      repeat (300) begin
        if (i_done || bus_err) seen = 1'b1;
        step();
      end
      check("no_timeout_done", seen, 0);
      check("no_timeout_re", mem_re, 1);
    end
    i_req = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    check("abort_rdata", {i_rdata, d_rdata}, 0);
    step(); idle_check();
`endif

    // Random traffic; the finished port may drop or immediately re-request.
    repeat (150) begin
      if (!i_req && $urandom_range(0, 1) == 1) new_i();
      if (!d_req && $urandom_range(0, 1) == 1) new_d();
      if (!i_req && !d_req) begin
        step(); idle_check();
      end else begin
        run_access(int'($urandom_range(0, 4)), won);
        if (won) begin
          if ($urandom_range(0, 2) == 0) new_d(); else d_req = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) new_i(); else i_req = 1'b0;
        end
        step(); idle_check();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single external memory bus between the instruction-fetch port (address phase driven from the CU fetch states) and the data port (loads/stores from dbus_re/dbus_we). Runs a registered request/done handshake per port, drives the memory bus, and returns a combinational stall to the control unit while any accepted request is outstanding. It sits between the core (control unit plus datapath) and the memory/bus fabric.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8
TIMEOUT_CYCLES, 255, access-cycle limit before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
i_req  input  1  ifetch request, level, held until i_done
i_addr  input  ADDR_W  fetch address
i_rdata  output  DATA_W  fetched word, registered
i_done  output  1  one-cycle completion pulse, ifetch
d_req  input  1  data request, level, held until d_done
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  DATA_W/8  store byte enables
d_rdata  output  DATA_W  load data, registered
d_done  output  1  one-cycle completion pulse, data
mem_addr  output  ADDR_W  bus address, registered
mem_wdata  output  DATA_W  bus write data, registered
mem_be  output  DATA_W/8  bus byte enables (all ones for reads)
mem_re  output  1  bus read strobe
mem_we  output  1  bus write strobe
mem_rdata  input  DATA_W  bus read data, valid with mem_ready
mem_ready  input  1  bus completes the current access
grant  output  2  bus_grant_t: NONE/IFETCH/DATA, current owner
bus_err  output  1  pulses with done on an aborted access
stall  output  1  to control unit: (i_req & ~i_done) | (d_req & ~d_done)

Behaviour:
- Reset (asynchronous, any time, including mid-access): state IDLE; grant NONE; mem_re, mem_we, i_done, d_done and bus_err 0; mem_addr, mem_wdata, mem_be, i_rdata and d_rdata 0; last_grant IFETCH. The in-flight bus access is abandoned and memory must discard it.
- FSM states: IDLE, I_ACC, D_ACC, RESP.
- IDLE, arbitration:
  - Only d_req: go to D_ACC.
  - Only i_req: go to I_ACC.
  - Both: the port not equal to last_grant wins (round robin). After reset data wins the first tie.
- Entering an ACC state: register addr, wdata and be from the winner. Set mem_re (i_req, or d_req with d_we=0) or mem_we (d_we=1). Set grant. Update last_grant.
- ACC state: strobes held stable until mem_ready is sampled 1.
  - On mem_ready: capture mem_rdata into the owner's rdata (loads and ifetch only; stores leave d_rdata unchanged). Drop strobes. Go to RESP.
  - mem_ready is ignored in IDLE and RESP.
- RESP: the owner's done is 1 for exactly this cycle. grant returns to NONE. Requests are ignored. Next state IDLE.
- Requester rules: keep req and operands stable from request until done. Drop or replace req at the edge ending the done cycle. A req still high in IDLE is treated as a new request.
- Latency: req high in cycle 0, strobe in cycle 1. With mem_ready=1 in cycle 1, done in cycle 2. Back-to-back issue rate is 1 access per 3 cycles.
- rdata registers hold their value until the next completion on the same port.
- stall is combinational. It deasserts in the done cycle so the CU advances on that edge.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: instantiate a counter cleared on entry to any ACC state and incremented each ACC cycle without mem_ready. When it reaches TIMEOUT_CYCLES: drop strobes, go to RESP, pulse done together with bus_err=1, and load the owner's rdata with 0.
- Not defined: ACC waits indefinitely and bus_err is tied 0. The port list is identical in both builds.

Decomposition:
- Types package gains bus_grant_t (GRANT_NONE, GRANT_IFETCH, GRANT_DATA) and arb_state_t (ARB_IDLE, ARB_I_ACC, ARB_D_ACC, ARB_RESP).
- Sub-module bus_watchdog (clk, rst, clear, tick, expired; parameter LIMIT) is instantiated only under BUS_TIMEOUT_EN. The counter width is $clog2(LIMIT+1).

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory returns 0x00500093 with mem_ready in the first ACC cycle -> mem_re=1 in cycle 1, i_done and i_rdata=0x00500093 in cycle 2, stall low in cycle 2.
- Store with 3 wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we, mem_be=4'b0011 and data held 4 cycles; d_done one cycle later; d_rdata unchanged.
- Tie after reset: i_req and d_req high together -> data served first, then ifetch. Repeat with both high -> ifetch first (last_grant=DATA).
- Reset mid-access: assert rst during D_ACC -> strobes, grant and done drop immediately. After release, the arbiter is in IDLE and re-arbitrates held requests.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ready held 0 -> strobe drops after 8 ACC cycles; i_done and bus_err pulse together; i_rdata=0. Without the macro the bench sees no done after 300 cycles.
- Held req across done: i_req held high past i_done -> new fetch issued, mem_re reasserts 1 cycle after RESP.
